// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind the UART byte receiver: SYNC, LEN, payload, CHK framing,
// payload buffering for a downstream consumer, and inter-byte timeout supervision.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hAA,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 5560
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_rst,
  output logic       pkt_ready,
  input  logic       pkt_ack,
  output logic [4:0] pkt_len,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       err_len,
  output logic       err_chksum,
  output logic       err_timeout,
  output logic       rx_overrun,
  output logic [2:0] state
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CHK     = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

  localparam int          AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [12:0] TO_LAST  = 13'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  len_q, len_d;
  logic        ready_q, ready_d;
  logic        err_len_q, err_len_d;
  logic        err_chk_q, err_chk_d;
  logic        err_to_q, err_to_d;
  logic        ovr_q, ovr_d;
  logic [7:0]  rd_data_q;
  logic        wr_en;
  logic [7:0]  mem_q [MAX_LEN];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    len_d     = len_q;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    err_to_d  = 1'b0;
    ovr_d     = 1'b0;
    wr_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (rx_valid && rx_data == SYNC_BYTE) state_d = ST_LEN;
      end
      ST_LEN, ST_PAYLOAD, ST_CHK: begin
        if (rx_valid) begin
          cnt_d = '0;
          case (state_q)
            ST_LEN: begin
              if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                err_len_d = 1'b1;
                state_d   = ST_IDLE;
              end else begin
                len_d   = rx_data[4:0];
                sum_d   = rx_data;
                idx_d   = '0;
                state_d = ST_PAYLOAD;
              end
            end
            ST_PAYLOAD: begin
              wr_en = 1'b1;
              sum_d = sum_q + rx_data;
              idx_d = idx_q + 5'd1;
              if (idx_q == len_q - 5'd1) state_d = ST_CHK;
            end
            default: begin
              if (rx_data == sum_q) begin
                state_d = ST_HOLD;
              end else begin
                err_chk_d = 1'b1;
                state_d   = ST_IDLE;
              end
            end
          endcase
        end else if (cnt_q == TO_LAST) begin
          // Receiver likely lost bit alignment; abandon the packet and resync it.
          err_to_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 13'd1;
        end
      end
      ST_HOLD: begin
        cnt_d = '0;
        if (rx_valid) ovr_d = 1'b1;
        if (pkt_ack) state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      ready_q   <= 1'b0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
      err_to_q  <= 1'b0;
      ovr_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      ready_q   <= ready_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
      err_to_q  <= err_to_d;
      ovr_q     <= ovr_d;
      rd_data_q <= mem_q[rd_addr[AW-1:0]];
    end
  end

  // Payload storage is deliberately not reset; only bytes below pkt_len are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx_q[AW-1:0]] <= rx_data;
  end

  assign rx_rst      = err_to_q;
  assign err_timeout = err_to_q;
  assign pkt_ready   = ready_q;
  assign pkt_len     = len_q;
  assign rd_data     = rd_data_q;
  assign err_len     = err_len_q;
  assign err_chksum  = err_chk_q;
  assign rx_overrun  = ovr_q;
  assign state       = state_q;

endmodule
